three_rr_arbiter: RTL and testbench
===================================

THREE_RR_ARBITER -- requirements
Module: three_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: the maximum number of consecutive grant cycles before forced rotation; it is used only when THREE_RR_ARBITER_TIMEOUT_EN is defined; the legal range is 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port req, input, 3 bits: the request lines; bit i belongs to requester i.
REQ-005 SHALL have port gnt, output, 3 bits: a registered grant, one-hot or zero.
REQ-006 SHALL have port gnt_id, output, 2 bits: the index of the current owner; it is 0 when gnt is 0.
REQ-007 SHALL have port busy, output, 1 bit: the OR of all gnt bits, registered with gnt.

Function
REQ-008 SHALL implement an FSM with two states:
- IDLE: no owner.
- GRANT: exactly one gnt bit set.
REQ-009 SHALL, in IDLE, on an edge where req!=0, enter GRANT and set gnt to the winning requester at that same edge; gnt is visible one cycle after req is sampled.
REQ-010 SHALL select the winner round-robin: search order last+1, last+2, last+3 (mod 3), where last is the index of the previous owner.
REQ-011 SHALL, in GRANT, hold gnt unchanged while req[owner]=1; other requests are ignored.
REQ-012 SHALL, in GRANT, on an edge where req[owner]=0:
- if other requests are pending, re-arbitrate and grant the next winner at that same edge (back-to-back, no idle cycle);
- otherwise, clear gnt and return to IDLE.
REQ-013 SHALL update last to the owner index at every edge where a new grant is issued.
REQ-014 SHALL never assert more than one gnt bit, and SHALL never grant a requester whose req is 0 at the granting edge.
REQ-015 SHALL treat all three simultaneous requests from reset as a grant to 0, then 1, then 2 as each releases.
REQ-016 SHALL keep busy equal to |gnt in every cycle.

Reset
REQ-017 SHALL, while rst=1 at an edge, set: gnt=0, gnt_id=0, busy=0, state=IDLE, last=2, hold counter=0; req is ignored.
REQ-018 SHALL, when rst asserts mid-grant, drop gnt on the next edge without completing the transfer; the first grant after reset obeys REQ-015 priority.

Configuration
REQ-019 SHALL, with THREE_RR_ARBITER_TIMEOUT_EN defined, count the owner's consecutive grant cycles; the counter clears on every new grant.
REQ-020 SHALL, with THREE_RR_ARBITER_TIMEOUT_EN defined, when the count reaches MAX_HOLD and another req is pending, re-arbitrate per REQ-010 excluding the current owner; if no other req is pending, the owner keeps the grant and the counter saturates.
REQ-021 SHALL, without THREE_RR_ARBITER_TIMEOUT_EN, contain no hold counter, leave MAX_HOLD unused, and let an owner hold the grant indefinitely.

Structure
REQ-022 SHALL place the state encodings (IDLE=1'b0, GRANT=1'b1), NUM_REQ=3 and the default MAX_HOLD in shared package three_rr_arbiter_pkg.
REQ-023 SHALL implement the rotating priority pick as the combinational sub-module rr_pick:
- inputs: req[2:0], last[1:0], exclude mask[2:0];
- outputs: valid and idx[1:0].

Verification
REQ-024 SHALL cover reset then req=3'b111 held, with each owner dropping req one cycle after grant:
- gnt sequence 001, 010, 100, with no idle cycle between them;
- busy=1 throughout the sequence.
REQ-025 SHALL cover req=3'b010 for 4 cycles, then 0: gnt=010 and gnt_id=1 from the cycle after req rises; gnt=000 and busy=0 one cycle after req falls.
REQ-026 SHALL cover the case where owner 0 holds the grant and req[2] rises, then req[0] falls: gnt goes from 001 to 100 at the falling edge, and last=2.
REQ-027 SHALL cover rst=1 for one cycle while gnt=100: the next cycle shows gnt=000 and gnt_id=0; with req=111 afterwards, gnt=001.
REQ-028 SHALL cover, with TIMEOUT_EN defined and MAX_HOLD=4, req[0] held high and req[1] high: gnt=001 for 4 cycles, then 010.
REQ-029 SHALL cover, with TIMEOUT_EN defined, req[0] held alone for 20 cycles: gnt=001 for all 20 cycles.

Source files
------------

// File: rtl/three_rr_arbiter_pkg.sv
// rtl/three_rr_arbiter_pkg.sv - shared types and constants for the three-way round-robin arbiter
//
// Contents:
//   state_t          - arbiter FSM state (IDLE = 1'b0, GRANT = 1'b1)
//   NUM_REQ          - number of requesters (3)
//   DEFAULT_MAX_HOLD - default hold limit used when the timeout feature is built in
package three_rr_arbiter_pkg;

  localparam int NUM_REQ          = 3;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/three_rr_arbiter_rr_pick.sv
// rtl/three_rr_arbiter_rr_pick.sv - combinational rotating-priority pick among three requesters
//
// Ports:
//   req     in  [2:0]  request lines
//   last    in  [1:0]  index of the previous owner; search starts at last+1
//   exclude in  [2:0]  requesters that may not win this pick
//   valid   out        a winner was found
//   idx     out [1:0]  index of the winner (0 when valid is 0)
module rr_pick
  import three_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         pos;

  always_comb begin
    cand  = req & ~exclude;
    valid = 1'b0;
    idx   = 2'd0;
    pos   = 2'd0;
    // Visit last+1, last+2, last+3 (mod 3); the first candidate seen wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = 2'((32'(last) + k) % NUM_REQ);
      if (!valid && cand[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/three_rr_arbiter.sv
// rtl/three_rr_arbiter.sv - three-requester round-robin arbiter with registered grant
//
// Optional feature: define THREE_RR_ARBITER_TIMEOUT_EN to force rotation after
// MAX_HOLD consecutive grant cycles when another requester is waiting.
//
// Ports:
//   clk     in         clock, rising edge
//   rst     in         synchronous active-high reset
//   req     in  [2:0]  request lines, bit i = requester i
//   gnt     out [2:0]  registered one-hot (or zero) grant
//   gnt_id  out [1:0]  index of the current owner, 0 when idle
//   busy    out        |gnt, registered alongside gnt
module three_rr_arbiter
  import three_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("MAX_HOLD must be within 2..255");
  end

  state_t     state;
  logic [1:0] last;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic       issue;
  logic       release_gnt;
  logic       owner_gone;
  logic       expired;

`ifdef THREE_RR_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  // Completed grant cycles of the current owner beyond the first.
  logic [7:0] hold_cnt;
`endif

  // The current owner is always excluded: on release its req is already 0,
  // and on timeout it must not win its own rotation.
  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .exclude(gnt),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    owner_gone = (state == GRANT) && !req[gnt_id];
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
    expired = (state == GRANT) && (hold_cnt >= HOLD_LIM);
`else
    expired = 1'b0;
`endif
    issue       = pick_valid && ((state == IDLE) || owner_gone || expired);
    release_gnt = owner_gone && !pick_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= 2'd0;
      busy   <= 1'b0;
      last   <= 2'd2;
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else if (issue) begin
      state  <= GRANT;
      gnt    <= NUM_REQ'(1) << pick_idx;
      gnt_id <= pick_idx;
      busy   <= 1'b1;
      last   <= pick_idx;
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else if (release_gnt) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= 2'd0;
      busy   <= 1'b0;
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
      // Owner keeps the grant; count saturates at the limit when nobody else waits.
      if (state == GRANT && hold_cnt < HOLD_LIM) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_three_rr_arbiter.sv
// tb/tb_three_rr_arbiter.sv - self-checking bench for three_rr_arbiter
module tb_three_rr_arbiter;

`ifdef THREE_RR_ARBITER_TIMEOUT_EN
  localparam int TB_MAX_HOLD = 4;
`else
  localparam int TB_MAX_HOLD = 8;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int checks;
  int failures;

  // Reference model: owner index (-1 = none), previous owner, cycles held.
  int m_owner;
  int m_last;
  int m_cnt;

  three_rr_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .gnt_id(gnt_id),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic [2:0] r, input logic rs);
    bit holds;
    bit expired;
    int winner;
    int c;
    if (rs) begin
      m_owner = -1;
      m_last  = 2;
      m_cnt   = 0;
      return;
    end
    holds   = (m_owner >= 0) && r[m_owner];
    expired = 1'b0;
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
    expired = holds && (m_cnt >= TB_MAX_HOLD - 1);
`endif
    if (holds && !expired) begin
      if (m_cnt < TB_MAX_HOLD - 1) m_cnt++;
      return;
    end
    winner = -1;
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (winner < 0 && r[c] && c != m_owner) winner = c;
    end
    if (winner >= 0) begin
      m_owner = winner;
      m_last  = winner;
      m_cnt   = 0;
    end else if (!holds) begin
      m_owner = -1;
      m_cnt   = 0;
    end
  endtask

  function automatic logic [2:0] exp_gnt();
    logic [2:0] one;
    one = 3'b001;
    return (m_owner < 0) ? 3'b000 : (one << m_owner);
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner < 0) ? 2'd0 : 2'(m_owner);
  endfunction

  task automatic step(input logic [2:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic test_reset();
    step(3'b111, 1'b1);
    step(3'b111, 1'b1);
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b want=000", gnt); end
    checks++;
    if (gnt_id !== 2'd0) begin failures++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_all_three();
    logic [2:0] want [3];
    logic [2:0] rq   [3];
    want = '{3'b001, 3'b010, 3'b100};
    rq   = '{3'b111, 3'b110, 3'b100};
    for (int i = 0; i < 3; i++) begin
      step(rq[i], 1'b0);
      checks++;
      if (gnt !== want[i]) begin failures++; $display("FAIL all_three_gnt[%0d] got=%b want=%b", i, gnt, want[i]); end
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL all_three_busy[%0d] got=%b want=1", i, busy); end
    end
    step(3'b000, 1'b0);
    checks++;
    if (gnt !== 3'b000) begin failures++; $display("FAIL all_three_release got=%b want=000", gnt); end
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin
      step(3'b010, 1'b0);
      checks++;
      if (gnt !== 3'b010 || gnt_id !== 2'd1) begin
        failures++;
        $display("FAIL single_hold[%0d] got=%b/%0d want=010/1", i, gnt, gnt_id);
      end
    end
    step(3'b000, 1'b0);
    checks++;
    if (gnt !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_release got=%b/%b want=000/0", gnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    step(3'b001, 1'b0);
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL b2b_first got=%b want=001", gnt); end
    step(3'b101, 1'b0);
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL b2b_hold got=%b want=001", gnt); end
    step(3'b100, 1'b0);
    checks++;
    if (gnt !== 3'b100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_handoff got=%b/%0d/%b want=100/2/1", gnt, gnt_id, busy);
    end
  endtask

  task automatic test_reset_mid();
    step(3'b100, 1'b0);
    checks++;
    if (gnt !== 3'b100) begin failures++; $display("FAIL mid_pre got=%b want=100", gnt); end
    step(3'b100, 1'b1);
    checks++;
    if (gnt !== 3'b000 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d want=000/0", gnt, gnt_id);
    end
    step(3'b111, 1'b0);
    checks++;
    if (gnt !== 3'b001) begin failures++; $display("FAIL mid_after got=%b want=001", gnt); end
    step(3'b000, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0] r;
    logic [2:0] prev;
    logic       rs;
    prev = 3'b000;
    for (int i = 0; i < 600; i++) begin
      r = prev;
      for (int b = 0; b < 3; b++) if ($urandom_range(99) < 25) r[b] = ~r[b];
      rs = ($urandom_range(59) == 0);
      step(r, rs);
      prev = r;
      checks++;
      if (gnt !== exp_gnt() || gnt_id !== exp_id() || busy !== (m_owner >= 0)) begin
        failures++;
        $display("FAIL random[%0d] req=%b got=%b/%0d/%b want=%b/%0d/%b",
                 i, r, gnt, gnt_id, busy, exp_gnt(), exp_id(), m_owner >= 0);
      end
      checks++;
      if (!$onehot0(gnt) || (gnt & ~r) !== 3'b000 || busy !== (|gnt)) begin
        failures++;
        $display("FAIL random_invariant[%0d] got=%b req=%b busy=%b want onehot0 subset of req", i, gnt, r, busy);
      end
    end
    step(3'b000, 1'b0);
  endtask

`ifdef THREE_RR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    step(3'b000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(3'b011, 1'b0);
      checks++;
      if (gnt !== 3'b001) begin failures++; $display("FAIL timeout_hold[%0d] got=%b want=001", i, gnt); end
    end
    step(3'b011, 1'b0);
    checks++;
    if (gnt !== 3'b010) begin failures++; $display("FAIL timeout_rotate got=%b want=010", gnt); end
    step(3'b000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(3'b001, 1'b0);
      checks++;
      if (gnt !== 3'b001) begin failures++; $display("FAIL timeout_alone[%0d] got=%b want=001", i, gnt); end
    end
    step(3'b000, 1'b0);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    m_owner  = -1;
    m_last   = 2;
    m_cnt    = 0;
    req      = 3'b000;
    rst      = 1'b1;
    test_reset();
    test_all_three();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef THREE_RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
